// File: rtl/can_bit_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : can_pkg
// Description : Shared types and constants for the CAN receive bit-timing
//               path (sampler state encoding, bus level names, idle length).
// Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

    // Sampler operating state.
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,   // hunting for a long recessive run
        IDLE      = 2'd1,   // bus idle, waiting for SOF
        RUN       = 2'd2    // inside a frame, strobing bits
    } can_state_t;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    // Consecutive recessive bits that declare the bus idle.
    localparam int CAN_IDLE_BITS = 11;

endpackage
`default_nettype wire

// File: rtl/can_bit_sampler_if.sv
`default_nettype none
// ============================================================================
// Interface   : can_bit_sampler_if
// Description : Line and bit-stream signals of the CAN bit sampler.
//               slave  : sampler side (takes RX/enable, drives bit stream)
//               master : consumer/driver side
//   i_Rx_Serial  raw asynchronous RX line (1 = recessive)
//   i_Enable     sampler enable
//   o_Bit        last sampled bit
//   o_Bit_Valid  1-cycle strobe, o_Bit is new
//   o_Bus_Idle   high while the bus is idle
//   o_Hard_Sync  1-cycle strobe on the SOF edge
// Revision    : 1.0 - initial release
// ============================================================================
interface can_bit_sampler_if;
    logic i_Rx_Serial;
    logic i_Enable;
    logic o_Bit;
    logic o_Bit_Valid;
    logic o_Bus_Idle;
    logic o_Hard_Sync;

    modport slave (
        input  i_Rx_Serial,
        input  i_Enable,
        output o_Bit,
        output o_Bit_Valid,
        output o_Bus_Idle,
        output o_Hard_Sync
    );

    modport master (
        output i_Rx_Serial,
        output i_Enable,
        input  o_Bit,
        input  o_Bit_Valid,
        input  o_Bus_Idle,
        input  o_Hard_Sync
    );
endinterface
`default_nettype wire

// File: rtl/can_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : can_rx_sync
// Description : Two-flop synchroniser for the raw CAN RX line plus a
//               previous-value flop for recessive-to-dominant edge detect.
//   i_Clock      system clock
//   i_Rst_n      synchronous reset, active-low (all flops to recessive)
//   i_Rx_Serial  raw asynchronous RX line
//   o_Rx_Sync    synchronised RX level (2 cycles behind the pin)
//   o_Fall       1-cycle pulse while prev is recessive and sync is dominant
// Revision    : 1.0 - initial release
// ============================================================================
module can_rx_sync
    import can_pkg::*;
(
    input  wire logic i_Clock,
    input  wire logic i_Rst_n,
    input  wire logic i_Rx_Serial,
    output logic      o_Rx_Sync,
    output logic      o_Fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_meta <= CAN_RECESSIVE;
            r_sync <= CAN_RECESSIVE;
            r_prev <= CAN_RECESSIVE;
        end else begin
            r_meta <= i_Rx_Serial;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_Rx_Sync = r_sync;
    assign o_Fall    = (r_prev == CAN_RECESSIVE) && (r_sync == CAN_DOMINANT);

endmodule
`default_nettype wire

// File: rtl/can_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module      : can_bit_sampler
// Description : CAN receive bit timing. Synchronises RX, detects bus idle,
//               hard-syncs on SOF, resyncs (SJW-limited) on recessive-to-
//               dominant edges and strobes one sampled bit per bit time.
//   i_Clock  system clock
//   i_Rst_n  synchronous reset, active-low
//   bus      can_bit_sampler_if.slave (RX, enable, bit stream, status)
// Revision    : 1.0 - initial release
// ============================================================================
module can_bit_sampler
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int SAMPLE_POINT = 7,
    parameter int SJW          = 1,
    parameter int IDLE_BITS    = CAN_IDLE_BITS
) (
    input  wire logic        i_Clock,
    input  wire logic        i_Rst_n,
    can_bit_sampler_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int RUN_W = $clog2(IDLE_BITS + 1);

    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] c_SJW        = CNT_W'(SJW);
    localparam logic [CNT_W-1:0] c_SHORT_MIN  = CNT_W'(CLKS_PER_BIT - SJW);
    // The cycle in which a sync edge is seen is tq 0 of the new bit, so the
    // counter carries on from 1 afterwards.
    localparam logic [CNT_W-1:0] c_CNT_AFTER_SYNC = CNT_W'(1);
    localparam logic [RUN_W-1:0] c_RUN_IDLE   = RUN_W'(IDLE_BITS);

    logic             w_rx;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_sample;
    logic [RUN_W-1:0] w_run_next;
    logic             w_resync;

    can_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RUN_W-1:0] r_run;
    logic             r_bit;
    logic             r_bit_valid;
    logic             r_bus_idle;
    logic             r_hard_sync;

    can_rx_sync u_rx_sync (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Rx_Serial (bus.i_Rx_Serial),
        .o_Rx_Sync   (w_rx),
        .o_Fall      (w_fall)
    );

    always_comb begin
        w_cnt_inc = (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
        w_sample  = (r_cnt == c_CNT_SAMPLE);
        // Saturating recessive-run count, cleared by any dominant sample.
        if (w_rx == CAN_RECESSIVE) begin
            w_run_next = (r_run == c_RUN_IDLE) ? r_run : r_run + 1'b1;
        end else begin
            w_run_next = '0;
        end
        // Edge at tq 0 needs no correction; edges in the phase-error window
        // on either side of the nominal edge restart the bit.
        w_resync = w_fall && (r_cnt != '0) &&
                   ((r_cnt <= c_SJW) || (r_cnt >= c_SHORT_MIN));
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state     <= WAIT_IDLE;
            r_cnt       <= '0;
            r_run       <= '0;
            r_bit       <= CAN_RECESSIVE;
            r_bit_valid <= 1'b0;
            r_bus_idle  <= 1'b0;
            r_hard_sync <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            r_hard_sync <= 1'b0;
            if (!bus.i_Enable) begin
                r_state    <= WAIT_IDLE;
                r_cnt      <= '0;
                r_run      <= '0;
                r_bus_idle <= 1'b0;
            end else begin
                case (r_state)
                    WAIT_IDLE: begin
                        r_cnt <= w_cnt_inc;
                        if (w_sample) begin
                            r_run <= w_run_next;
                            if (w_run_next == c_RUN_IDLE) begin
                                r_state    <= IDLE;
                                r_cnt      <= '0;
                                r_bus_idle <= 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        r_cnt <= '0;
                        if (w_fall) begin
                            r_state     <= RUN;
                            r_cnt       <= c_CNT_AFTER_SYNC;
                            r_run       <= '0;
                            r_hard_sync <= 1'b1;
                            r_bus_idle  <= 1'b0;
                        end
                    end
                    RUN: begin
                        r_cnt <= w_resync ? c_CNT_AFTER_SYNC : w_cnt_inc;
                        // The sample point lies outside both resync windows,
                        // so a sample and a resync never coincide.
                        if (w_sample) begin
                            r_bit       <= w_rx;
                            r_bit_valid <= 1'b1;
                            r_run       <= w_run_next;
                            if (w_run_next == c_RUN_IDLE) begin
                                r_state    <= IDLE;
                                r_cnt      <= '0;
                                r_bus_idle <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= WAIT_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_Bit       = r_bit;
    assign bus.o_Bit_Valid = r_bit_valid;
    assign bus.o_Bus_Idle  = r_bus_idle;
    assign bus.o_Hard_Sync = r_hard_sync;

endmodule
`default_nettype wire
